// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM state encoding, requester IDs and default geometry.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic PORT_MA  = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int DEFAULT_DEPTH   = 10001;
    localparam int DEFAULT_MEM_LAT = 2;

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Grants are combinational; the pointer moves only when a grant is issued.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_r;

    // Grant selection: on a tie the port not granted last wins
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = (last_r == PORT_AUX);
                gnt1 = (last_r == PORT_MA);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Last-grant pointer, starts as if port 1 had just been served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= PORT_AUX;
        end else if (gnt0 || gnt1) begin
            last_r <= gnt1 ? PORT_AUX : PORT_MA;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the MA stage and an auxiliary port.
// One transaction in flight; registered command and response, fixed read latency.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_valid,
    input  logic              rq0_we,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ready,
    output logic              rs0_valid,
    output logic [DATA_W-1:0] rs0_rdata,
    output logic              rs0_err,
    input  logic              rq1_valid,
    input  logic              rq1_we,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ready,
    output logic              rs1_valid,
    output logic [DATA_W-1:0] rs1_rdata,
    output logic              rs1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ma_stall
);

    state_t            state_r, state_nxt_s;
    logic              owner_r, we_r;
    logic [2:0]        cnt_r;
    logic              gnt0_s, gnt1_s, arb_en_s, accept_s, issue_s;
    logic              sel_port_s, sel_we_s, sel_err_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              resp_fire_s, resp_port_s, resp_err_s;
    logic [DATA_W-1:0] resp_data_s;
    logic              mem_en_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              rs0_valid_r, rs0_err_r, rs1_valid_r, rs1_err_r;
    logic [DATA_W-1:0] rs0_rdata_r, rs1_rdata_r;

    // Reset gates the enable so neither port sees ready while held in reset
    assign arb_en_s = (state_r == IDLE) && rst;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (arb_en_s),
        .req0 (rq0_valid),
        .req1 (rq1_valid),
        .gnt0 (gnt0_s),
        .gnt1 (gnt1_s)
    );

    // Winner mux, range check and next-state / response decode
    always_comb begin
        sel_port_s  = gnt1_s ? PORT_AUX : PORT_MA;
        sel_we_s    = gnt1_s ? rq1_we : rq0_we;
        sel_addr_s  = gnt1_s ? rq1_addr : rq0_addr;
        sel_wdata_s = gnt1_s ? rq1_wdata : rq0_wdata;
        accept_s    = gnt0_s || gnt1_s;
        sel_err_s   = (sel_addr_s >= ADDR_W'(DEPTH));
        issue_s     = accept_s && !sel_err_s;
        state_nxt_s = state_r;
        resp_fire_s = 1'b0;
        resp_port_s = owner_r;
        resp_err_s  = 1'b0;
        resp_data_s = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (accept_s && sel_err_s) begin
                    state_nxt_s = RESP;
                    resp_fire_s = 1'b1;
                    resp_port_s = sel_port_s;
                    resp_err_s  = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r) begin
                    state_nxt_s = RESP;
                    resp_fire_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                // Counter at 1 marks the edge on which read data is valid
                if (cnt_r <= 3'd1) begin
                    state_nxt_s = RESP;
                    resp_fire_s = 1'b1;
                    resp_data_s = mem_rdata;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state, transaction context and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            owner_r <= PORT_MA;
            we_r    <= 1'b0;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                owner_r <= sel_port_s;
                we_r    <= sel_we_s;
            end else begin
                owner_r <= owner_r;
                we_r    <= we_r;
            end
            if (state_r == ACCESS) begin
                cnt_r <= 3'(MEM_LAT);
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 3'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Memory command registers, strobed for the single ACCESS cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_en_r <= issue_s;
            mem_we_r <= issue_s && sel_we_s;
            if (issue_s) begin
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Response registers, zero except in the owner's RESP cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs0_valid_r <= 1'b0;
            rs0_err_r   <= 1'b0;
            rs0_rdata_r <= {DATA_W{1'b0}};
            rs1_valid_r <= 1'b0;
            rs1_err_r   <= 1'b0;
            rs1_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rs0_valid_r <= resp_fire_s && (resp_port_s == PORT_MA);
            rs0_err_r   <= resp_fire_s && (resp_port_s == PORT_MA) && resp_err_s;
            rs0_rdata_r <= (resp_fire_s && (resp_port_s == PORT_MA)) ? resp_data_s : {DATA_W{1'b0}};
            rs1_valid_r <= resp_fire_s && (resp_port_s == PORT_AUX);
            rs1_err_r   <= resp_fire_s && (resp_port_s == PORT_AUX) && resp_err_s;
            rs1_rdata_r <= (resp_fire_s && (resp_port_s == PORT_AUX)) ? resp_data_s : {DATA_W{1'b0}};
        end
    end

    assign rq0_ready = gnt0_s;
    assign rq1_ready = gnt1_s;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign rs0_valid = rs0_valid_r;
    assign rs0_rdata = rs0_rdata_r;
    assign rs0_err   = rs0_err_r;
    assign rs1_valid = rs1_valid_r;
    assign rs1_rdata = rs1_rdata_r;
    assign rs1_err   = rs1_err_r;
    assign ma_stall  = (rq0_valid && !gnt0_s) ||
                       ((owner_r == PORT_MA) && ((state_r == ACCESS) || (state_r == WAIT)));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 2-cycle-latency memory model.
// Expected values are hand-derived from the request/response timing.
module tb_dmem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 10001;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rq0_valid = 1'b0, rq0_we = 1'b0, rq0_ready;
    logic [ADDR_W-1:0] rq0_addr = '0;
    logic [DATA_W-1:0] rq0_wdata = '0;
    logic              rq1_valid = 1'b0, rq1_we = 1'b0, rq1_ready;
    logic [ADDR_W-1:0] rq1_addr = '0;
    logic [DATA_W-1:0] rq1_wdata = '0;
    logic              rs0_valid, rs0_err, rs1_valid, rs1_err;
    logic [DATA_W-1:0] rs0_rdata, rs1_rdata;
    logic              mem_en, mem_we, ma_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    int mem_en_cnt = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ready(rq0_ready), .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata), .rs0_err(rs0_err),
        .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ready(rq1_ready), .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata), .rs1_err(rs1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ma_stall(ma_stall)
    );

    // Memory model: 256 words aliased on addr[7:0], two-stage read pipe
    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;
    logic [31:0] pipe0 = 32'hA5A5A5A5;
    logic [31:0] pipe1 = 32'hA5A5A5A5;
    assign mem_rdata = pipe1;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 5) ? 32'hDEADBEEF : (32'h10000000 | i);
            mem_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        pipe0 <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'hA5A5A5A5;
        pipe1 <= pipe0;
    end

    always @(negedge clk) begin
        if (mem_en) mem_en_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request on a port and check response latency, data and error
    task automatic transact(input string tag, input bit port, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input bit exp_err, input int exp_lat);
        bit got;
        int n, wrong;
        logic [31:0] rdata;
        logic err;
        if (port) begin
            rq1_valid = 1'b1; rq1_we = we; rq1_addr = addr; rq1_wdata = wdata;
        end else begin
            rq0_valid = 1'b1; rq0_we = we; rq0_addr = addr; rq0_wdata = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = port ? rq1_ready : rq0_ready;
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        got = 1'b0; n = 0; wrong = 0; rdata = 32'hFFFFFFFF; err = 1'bx;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (port ? rs0_valid : rs1_valid) wrong++;
            if (port ? rs1_valid : rs0_valid) begin
                got = 1'b1; n = i;
                rdata = port ? rs1_rdata : rs0_rdata;
                err   = port ? rs1_err : rs0_err;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_wrong_port"}, 32'(wrong), 32'd0);
    endtask

    // Both ports request together; grants and responses must come 0 then 1
    task automatic pair(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1);
        int gq[$];
        int rq[$];
        bit r0, r1, g0, g1, both;
        logic [31:0] d0, d1;
        rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = a0;
        rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = a1;
        r0 = 1'b0; r1 = 1'b0; both = 1'b0; d0 = 32'hFFFFFFFF; d1 = 32'hFFFFFFFF;
        for (int i = 0; i < 40 && !(r0 && r1); i++) begin
            @(negedge clk);
            g0 = rq0_ready; g1 = rq1_ready;
            if (g0 && g1) both = 1'b1;
            if (g0) gq.push_back(0);
            if (g1) gq.push_back(1);
            if (rs0_valid) begin rq.push_back(0); d0 = rs0_rdata; r0 = 1'b1; end
            if (rs1_valid) begin rq.push_back(1); d1 = rs1_rdata; r1 = 1'b1; end
            @(posedge clk); #1;
            if (g0) rq0_valid = 1'b0;
            if (g1) rq1_valid = 1'b0;
        end
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        chk({tag, "_grant_order"}, (gq.size() == 2) ? 32'((gq[0] << 4) | gq[1]) : 32'hEEEE, 32'h01);
        chk({tag, "_resp_order"}, (rq.size() == 2) ? 32'((rq[0] << 4) | rq[1]) : 32'hEEEE, 32'h01);
        chk({tag, "_both_ready"}, 32'(both), 32'd0);
        chk({tag, "_rdata0"}, d0, e0);
        chk({tag, "_rdata1"}, d1, e1);
    endtask

    initial begin
        int c, seen;
        logic [31:0] acc;

        // Reset held with MA request pending: no ready, stall follows valid
        @(posedge clk); #1;
        rq0_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(rq0_ready), 32'd0);
        chk("rst_stall_v1", 32'(ma_stall), 32'd1);
        rq0_valid = 1'b0;
        #1;
        chk("rst_stall_v0", 32'(ma_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        acc = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc = acc | 32'({rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs0_err, rs1_err,
                             mem_en, mem_we, ma_stall}) | rs0_rdata | rs1_rdata | mem_addr | mem_wdata;
        end
        chk("idle_outputs_zero", acc, 32'd0);
        chk("idle_no_mem_en", 32'(mem_en_cnt), 32'd0);
        @(posedge clk); #1;

        // First tie after reset goes to port 0, then alternation continues
        pair("pair1", 32'd5, 32'd6, 32'hDEADBEEF, 32'h10000006);
        pair("pair2", 32'd7, 32'd8, 32'h10000007, 32'h10000008);
        pair("pair3", 32'd9, 32'd10, 32'h10000009, 32'h1000000A);

        // Port 0 load of addr 5 with cycle-accurate checks
        rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 32'd5;
        @(negedge clk);
        chk("ld_ready_T", 32'(rq0_ready), 32'd1);
        chk("ld_stall_T", 32'(ma_stall), 32'd0);
        @(posedge clk); #1;
        rq0_valid = 1'b0;
        @(negedge clk);
        chk("ld_mem_en_T1", 32'(mem_en), 32'd1);
        chk("ld_mem_addr_T1", mem_addr, 32'd5);
        chk("ld_mem_we_T1", 32'(mem_we), 32'd0);
        chk("ld_stall_T1", 32'(ma_stall), 32'd1);
        @(negedge clk);
        chk("ld_mem_en_T2", 32'(mem_en), 32'd0);
        chk("ld_stall_T2", 32'(ma_stall), 32'd1);
        @(negedge clk);
        chk("ld_stall_T3", 32'(ma_stall), 32'd1);
        chk("ld_rs0_early", 32'(rs0_valid), 32'd0);
        @(negedge clk);
        chk("ld_rs0_valid_T4", 32'(rs0_valid), 32'd1);
        chk("ld_rs0_rdata_T4", rs0_rdata, 32'hDEADBEEF);
        chk("ld_rs0_err_T4", 32'(rs0_err), 32'd0);
        chk("ld_rs1_quiet_T4", 32'(rs1_valid), 32'd0);
        chk("ld_stall_T4", 32'(ma_stall), 32'd0);
        @(negedge clk);
        chk("ld_rs0_oneshot", 32'(rs0_valid), 32'd0);
        @(posedge clk); #1;

        // Store then load through both ports; port 1 wins twice when alone
        transact("st1_100", 1'b1, 1'b1, 32'd100, 32'h12345678, 32'd0, 1'b0, 2);
        transact("ld0_100", 1'b0, 1'b0, 32'd100, 32'd0, 32'h12345678, 1'b0, 4);
        transact("st0_20", 1'b0, 1'b1, 32'd20, 32'hCAFEF00D, 32'd0, 1'b0, 2);
        transact("ld1_20", 1'b1, 1'b0, 32'd20, 32'd0, 32'hCAFEF00D, 1'b0, 4);
        transact("ld1_7", 1'b1, 1'b0, 32'd7, 32'd0, 32'h10000007, 1'b0, 4);
        transact("ld0_last", 1'b0, 1'b0, 32'd10000, 32'd0, 32'h10000010, 1'b0, 4);

        // Out-of-range requests: error response at T+1, no memory command
        c = mem_en_cnt;
        transact("oor0", 1'b0, 1'b0, 32'd10001, 32'd0, 32'd0, 1'b1, 1);
        transact("oor1", 1'b1, 1'b1, 32'hFFFFFFFF, 32'h55555555, 32'd0, 1'b1, 1);
        chk("oor_no_mem_en", 32'(mem_en_cnt - c), 32'd0);

        // Reset during WAIT of a port 0 load drops the transaction
        rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 32'd5;
        @(negedge clk);
        chk("mid_accept", 32'(rq0_ready), 32'd1);
        @(posedge clk); #1;
        rq0_valid = 1'b0;
        @(posedge clk); #2;
        chk("mid_stall_wait", 32'(ma_stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_stall_clr", 32'(ma_stall), 32'd0);
        chk("mid_mem_en_clr", 32'(mem_en), 32'd0);
        chk("mid_rs0_clr", 32'(rs0_valid), 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rs0_valid || rs1_valid) seen++;
        end
        chk("mid_no_resp", 32'(seen), 32'd0);
        @(posedge clk); #1;
        transact("mid_after", 1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
